// File: rtl/sc_ulpi_pkg.sv
// Shared ULPI register-access definitions: TXCMD op codes, extended-address marker,
// the register-access FSM state type and the TXCMD encoder.
package sc_ulpi_pkg;

  localparam logic [1:0] REGW         = 2'b10;
  localparam logic [1:0] REGR         = 2'b11;
  localparam logic [5:0] EXT_REG_ADDR = 6'h2F;
  localparam logic [7:0] NOOP         = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE, S_TXCMD, S_EXTADR, S_WDATA, S_STP, S_RTA, S_RDATA, S_RTB, S_WAITDIR
  } ulra_state_t;

  // 0x2F itself and everything from 0x40 up need the extra address byte.
  function automatic logic is_ext(input logic [7:0] addr);
    return (addr == {2'b00, EXT_REG_ADDR}) || (addr >= 8'h40);
  endfunction

  function automatic logic [7:0] txcmd(input logic rd, input logic [7:0] addr);
    return {rd ? REGR : REGW, is_ext(addr) ? EXT_REG_ADDR : addr[5:0]};
  endfunction

endpackage

// File: rtl/sc_scbc_ulra.sv
// ULPI register access engine: turns ULLA_* requests into ULPI register write/read
// transactions, with PHY-preemption retry and a whole-transaction timeout.
module sc_scbc_ulra
  import sc_ulpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic       ULPICLK,
  input  logic       ULPIRSTB,
  input  logic       ULLA_REQ,
  output logic       ULLA_ACK,
  output logic       ULLA_ERR,
  input  logic       ULLA_WR0RD1,
  input  logic [7:0] ULLA_ADDR,
  input  logic [7:0] ULLA_WRDATA,
  output logic [7:0] URC_DATA,
  input  logic       LINK_IDLE,
  output logic       ULLA_BUSY,
  input  logic       ULPI_DIR,
  input  logic       ULPI_NXT,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE,
  output logic       ULPI_STP
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  ulra_state_t   state;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          rd_q;
  logic [7:0]    addr_q;
  logic [7:0]    wrdata_q;
  logic          start;
  logic          tmo;

  assign start = (state == S_IDLE) && ULLA_REQ && armed && !ULLA_BUSY &&
                 !ULPI_DIR && LINK_IDLE;

  // Only a transaction that has not yet been acknowledged can time out.
  assign tmo = ULLA_BUSY && !ULLA_ACK && (cnt == CNT_MAX) &&
               !(state inside {S_IDLE, S_STP, S_RDATA});

  assign ULPI_DATA_OE = !ULPI_DIR && (state inside {S_TXCMD, S_EXTADR, S_WDATA, S_STP});

  always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
    if (!ULPIRSTB) begin
      state       <= S_IDLE;
      cnt         <= '0;
      armed       <= 1'b1;
      rd_q        <= 1'b0;
      addr_q      <= 8'h00;
      wrdata_q    <= 8'h00;
      ULLA_ACK    <= 1'b0;
      ULLA_ERR    <= 1'b0;
      ULLA_BUSY   <= 1'b0;
      URC_DATA    <= NOOP;
      ULPI_DATA_O <= NOOP;
      ULPI_STP    <= 1'b0;
    end else begin
      ULLA_ACK <= 1'b0;
      ULLA_ERR <= 1'b0;
      ULPI_STP <= 1'b0;
      if (!ULLA_REQ) armed <= 1'b1;
      if (ULLA_ACK) ULLA_BUSY <= 1'b0;
      if (state != S_IDLE && cnt != CNT_MAX) cnt <= cnt + 1'b1;

      if (tmo) begin
        ULLA_ACK    <= 1'b1;
        ULLA_ERR    <= 1'b1;
        ULPI_STP    <= !ULPI_DIR;
        ULPI_DATA_O <= NOOP;
        state       <= ULPI_DIR ? S_RTB : S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            rd_q        <= ULLA_WR0RD1;
            addr_q      <= ULLA_ADDR;
            wrdata_q    <= ULLA_WRDATA;
            cnt         <= '0;
            armed       <= 1'b0;
            ULLA_BUSY   <= 1'b1;
            ULPI_DATA_O <= txcmd(ULLA_WR0RD1, ULLA_ADDR);
            state       <= S_TXCMD;
          end
          S_TXCMD: begin
            if (ULPI_DIR) begin
              ULPI_DATA_O <= NOOP;
              state       <= S_WAITDIR;
            end else if (ULPI_NXT) begin
              if (is_ext(addr_q)) begin
                ULPI_DATA_O <= addr_q;
                state       <= S_EXTADR;
              end else begin
                ULPI_DATA_O <= rd_q ? NOOP : wrdata_q;
                state       <= rd_q ? S_RTA : S_WDATA;
              end
            end
          end
          S_EXTADR: begin
            if (ULPI_DIR) begin
              ULPI_DATA_O <= NOOP;
              state       <= S_WAITDIR;
            end else if (ULPI_NXT) begin
              ULPI_DATA_O <= rd_q ? NOOP : wrdata_q;
              state       <= rd_q ? S_RTA : S_WDATA;
            end
          end
          S_WDATA: begin
            if (ULPI_DIR) begin
              ULPI_DATA_O <= NOOP;
              state       <= S_WAITDIR;
            end else if (ULPI_NXT) begin
              ULPI_DATA_O <= NOOP;
              ULPI_STP    <= 1'b1;
              ULLA_ACK    <= 1'b1;
              state       <= S_STP;
            end
          end
          S_STP:   state <= S_IDLE;
          S_RTA:   if (ULPI_DIR) state <= S_RDATA;
          S_RDATA: begin
            URC_DATA <= ULPI_DATA_I;
            ULLA_ACK <= 1'b1;
            state    <= S_RTB;
          end
          S_RTB:   if (!ULPI_DIR) state <= S_IDLE;
          // The PHY preempted us; replay the whole latched request once it lets go.
          S_WAITDIR: if (!ULPI_DIR) begin
            ULPI_DATA_O <= txcmd(rd_q, addr_q);
            state       <= S_TXCMD;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
